// File: rtl/cpu0_pkg.sv
// Shared CPU0 constants: datapath widths and the encoding decode treats as a bubble.
package cpu0_pkg;
    localparam int          INST_W   = 32;
    localparam int          ADDR_W   = 32;
    localparam logic [31:0] NOP_INST = 32'h0;
endpackage

// File: rtl/cpu0_sync_fifo.sv
// Generic synchronous FIFO: circular buffer with a clear input that empties it in one edge.
module cpu0_sync_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     wr_en_i,
    input  logic [W-1:0]             wr_data_i,
    input  logic                     rd_en_i,
    output logic [W-1:0]             rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ok, rd_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Self-guarding so a careless caller can never over/underflow.
    assign wr_ok = wr_en_i && !full_o && !clr_i;
    assign rd_ok = rd_en_i && !empty_o && !clr_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
            if (wr_ok && !rd_ok)      count_d = count_q + CW'(1);
            else if (!wr_ok && rd_ok) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/if_inst_queue.sv
// Fetch-to-decode prefetch queue: buffers {pc, inst} pairs, flushes on redirect,
// and presents a NOP with PC 0 to decode whenever nothing is queued.
module if_inst_queue
    import cpu0_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = INST_W,
    parameter int AW    = ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid_i,
    input  logic [IW-1:0]          if_inst_i,
    input  logic [AW-1:0]          if_pc_i,
    output logic                   if_ready_o,
    output logic                   id_valid_o,
    output logic [IW-1:0]          id_inst_o,
    output logic [AW-1:0]          id_pc_o,
    input  logic                   id_ready_i,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);
    logic [IW+AW-1:0] head;
    logic             wr_en, rd_en;

    // Ready depends only on occupancy, so a full queue refuses even when decode drains.
    assign if_ready_o = !full_o;
    assign id_valid_o = !empty_o;
    assign wr_en      = if_valid_i && if_ready_o && !flush_i;
    assign rd_en      = id_valid_o && id_ready_i && !flush_i;

    cpu0_sync_fifo #(
        .W     (IW + AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (flush_i),
        .wr_en_i   (wr_en),
        .wr_data_i ({if_pc_i, if_inst_i}),
        .rd_en_i   (rd_en),
        .rd_data_o (head),
        .count_o   (count_o),
        .empty_o   (empty_o),
        .full_o    (full_o)
    );

    // Storage is never reset, so mask stale contents when empty.
    assign id_inst_o = empty_o ? IW'(NOP_INST) : head[IW-1:0];
    assign id_pc_o   = empty_o ? '0 : head[IW +: AW];
endmodule

// File: tb/tb_if_inst_queue.sv
// Scoreboard bench for if_inst_queue: directed plan followed by randomized traffic.
module tb_if_inst_queue;
    localparam int DEPTH = 4;
    localparam int IW    = 32;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_valid_i = 1'b0;
    logic [IW-1:0] if_inst_i = '0;
    logic [AW-1:0] if_pc_i = '0;
    logic          if_ready_o;
    logic          id_valid_o;
    logic [IW-1:0] id_inst_o;
    logic [AW-1:0] id_pc_o;
    logic          id_ready_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [$clog2(DEPTH):0] count_o;
    logic          empty_o, full_o;

    if_inst_queue #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .if_valid_i(if_valid_i), .if_inst_i(if_inst_i), .if_pc_i(if_pc_i),
        .if_ready_o(if_ready_o),
        .id_valid_o(id_valid_o), .id_inst_o(id_inst_o), .id_pc_o(id_pc_o),
        .id_ready_i(id_ready_i), .flush_i(flush_i),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference: contents of the queue (mdl_q) and pending-read scoreboard (exp_q).
    logic [IW+AW-1:0] mdl_q[$];
    logic [IW+AW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue semantics at each edge: reset/flush empty it, else pop if decode takes, push if room.
    always @(posedge clk) begin
        if (rst || flush_i) begin
            mdl_q.delete();
            exp_q.delete();
        end else begin
            int sz;
            sz = mdl_q.size();
            if (id_ready_i && sz > 0) void'(mdl_q.pop_front());
            if (if_valid_i && sz < DEPTH) begin
                mdl_q.push_back({if_pc_i, if_inst_i});
                exp_q.push_back({if_pc_i, if_inst_i});
            end
        end
    end

    // Monitor: compare status every cycle, pop the scoreboard on each decode handshake.
    always @(negedge clk) begin
        if (!rst) begin
            int sz;
            sz = mdl_q.size();
            assert (count_o <= DEPTH) else $error("count_o out of range: %0d", count_o);
            chk("count", 64'(count_o), 64'(sz));
            chk("empty", 64'(empty_o), 64'(sz == 0));
            chk("full", 64'(full_o), 64'(sz == DEPTH));
            chk("if_ready", 64'(if_ready_o), 64'(sz != DEPTH));
            chk("id_valid", 64'(id_valid_o), 64'(sz != 0));
            if (sz == 0) begin
                chk("nop_inst", 64'(id_inst_o), 64'h0);
                chk("nop_pc", 64'(id_pc_o), 64'h0);
            end else begin
                chk("head_inst", 64'(id_inst_o), 64'(mdl_q[0][IW-1:0]));
                chk("head_pc", 64'(id_pc_o), 64'(mdl_q[0][IW +: AW]));
            end
            if (id_valid_o && id_ready_i && !flush_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_read", 64'({id_pc_o, id_inst_o}), 64'h0);
                end else begin
                    logic [IW+AW-1:0] e;
                    e = exp_q.pop_front();
                    chk("read_data", 64'({id_pc_o, id_inst_o}), 64'(e));
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [AW-1:0] pc, input logic [IW-1:0] inst,
                       input logic rdy, input logic fl, input logic r);
        if_valid_i = v;
        if_pc_i    = pc;
        if_inst_i  = inst;
        id_ready_i = rdy;
        flush_i    = fl;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset then idle
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 2);
        chk("rst_count", 64'(count_o), 64'h0);
        chk("rst_ready", 64'(if_ready_o), 64'h1);

        // Three writes held, then drain in order
        cyc(1'b1, 32'h0, 32'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h4, 32'h22, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h8, 32'h33, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1);
        chk("three_count", 64'(count_o), 64'h3);
        idle(1'b1, 4);

        // Fill, 5th write refused while a read fires, accepted next cycle
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'(16 + 4*i), 32'(32'h100 + i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", 64'(full_o), 64'h1);
        cyc(1'b1, 32'h50, 32'h55, 1'b1, 1'b0, 1'b0);
        chk("held_count", 64'(count_o), 64'h3);
        cyc(1'b1, 32'h50, 32'h55, 1'b0, 1'b0, 1'b0);
        chk("accept_count", 64'(count_o), 64'h4);
        idle(1'b1, 6);

        // Full-rate streaming, ten instructions
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'(32'h200 + 4*i), 32'(32'hA00 + i), 1'b1, 1'b0, 1'b0);
        idle(1'b1, 2);

        // Flush with concurrent write
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'(32'h300 + 4*i), 32'(32'h70 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h390, 32'h99, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 64'(count_o), 64'h0);
        chk("flush_valid", 64'(id_valid_o), 64'h0);
        idle(1'b0, 2);

        // Reset mid-stream with decode ready
        cyc(1'b1, 32'h400, 32'h81, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h404, 32'h82, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("rst_mid_valid", 64'(id_valid_o), 64'h0);
        chk("rst_mid_inst", 64'(id_inst_o), 64'h0);
        chk("rst_mid_pc", 64'(id_pc_o), 64'h0);

        // Randomized traffic with occasional flush/reset
        for (int i = 0; i < 400; i++) begin
            logic v, rdy, fl, r;
            v   = ($urandom_range(0, 99) < 65);
            rdy = ($urandom_range(0, 99) < 50);
            fl  = ($urandom_range(0, 99) < 4);
            r   = ($urandom_range(0, 199) < 2);
            cyc(v, $urandom(), $urandom(), rdy, fl, r);
        end
        idle(1'b1, DEPTH + 2);
        chk("final_drained", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_inst_queue.md
Name: if_inst_queue

Overview:
- Instruction prefetch queue between inst_fetch and the decode stage.
- Buffers fetched instruction/PC pairs so fetch keeps running while decode stalls.
- Presents the oldest pair to decode with a valid/ready handshake.
- Discards all contents on a branch/redirect flush.

Parameters:
- DEPTH, 4, number of entries; power of 2, >= 2
- IW, 32, instruction width
- AW, 32, PC width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- if_valid_i  input  1  fetch presents an instruction this cycle
- if_inst_i  input  IW  instruction word from inst_fetch
- if_pc_i  input  AW  PC of if_inst_i
- if_ready_o  output  1  queue accepts a write this cycle
- id_valid_o  output  1  head entry valid for decode
- id_inst_o  output  IW  head instruction
- id_pc_o  output  AW  head PC
- id_ready_i  input  1  decode consumes head this cycle
- flush_i  input  1  discard all entries (branch redirect)
- count_o  output  $clog2(DEPTH)+1  occupied entries
- empty_o  output  1  count_o == 0
- full_o  output  1  count_o == DEPTH

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Storage: circular buffer with rd_ptr and wr_ptr ($clog2(DEPTH) bits) and a count register. Pointers wrap naturally at DEPTH-1 -> 0.
- Write fire: if_valid_i && if_ready_o && !flush_i. Stores {if_pc_i, if_inst_i} at wr_ptr; wr_ptr+1.
- Read fire: id_valid_o && id_ready_i && !flush_i. rd_ptr+1.
- Count update:
  - Write only: count +1.
  - Read only: count -1.
  - Both: count unchanged.
- if_ready_o = !full_o, combinational from count only. It does not depend on id_ready_i, so a full queue never accepts, even if a read fires the same cycle.
- id_valid_o = !empty_o.
- id_inst_o and id_pc_o come from the entry at rd_ptr. They are forced to 0 when empty (IW'h0 is NOP).
- Latency: a pair written at edge N is visible on id_* after edge N (1 cycle). No combinational bypass when empty.
- Stability: while id_valid_o && !id_ready_i, id_inst_o and id_pc_o hold their values.
- FIFO order: entries leave in the order they arrived.
- Flush: when flush_i=1 at an edge:
  - rd_ptr, wr_ptr and count become 0.
  - A simultaneous write or read is discarded.
  - The cycle after, id_valid_o=0 and if_ready_o=1.
- Reset: same effect as flush, with rst priority over everything.
  - Output values after reset: id_valid_o=0, id_inst_o=0, id_pc_o=0, count_o=0, empty_o=1, full_o=0, if_ready_o=1.
  - Storage array is not reset; masking keeps outputs clean.
  - Reset mid-stream drops all entries.
- Overflow and underflow cannot occur: the gating above enforces it. The bench asserts count_o stays within 0..DEPTH.

Decomposition:
- Shared package cpu0_pkg holds:
  - INST_W=32
  - ADDR_W=32
  - NOP_INST=32'h0
- One natural sub-module: cpu0_sync_fifo. It is a generic width-parameterised synchronous FIFO with clear input, instantiated with width IW+AW.
- The if_inst_queue wrapper adds flush gating, output masking and the split of PC and instruction fields.

Test Plan:
- Reset 3 cycles, then idle -> id_valid_o=0, id_inst_o=0, if_ready_o=1, count_o=0, empty_o=1.
- Write (pc=0x0,inst=0x11), (0x4,0x22), (0x8,0x33) with id_ready_i=0 -> count_o=3. Then id_ready_i=1 -> id outputs 0x11, 0x22, 0x33 on consecutive cycles with the matching PCs, then empty_o=1.
- Fill 4 entries with id_ready_i=0 -> full_o=1, if_ready_o=0. A 5th write (0x55) is held by fetch and not stored. One read the same cycle leaves count_o=3. Next cycle the 0x55 write is accepted.
- Continuous write and read at full rate over 10 instructions (pointer wrap twice) -> count_o stays 1 and outputs arrive in order with 1-cycle latency.
- With 3 entries queued, assert flush_i together with if_valid_i=1 (0x99) -> next cycle count_o=0, id_valid_o=0, and 0x99 is not stored.
- Assert rst while 2 entries are queued and id_ready_i=1 -> next cycle all outputs are at their reset values and no read is observed.
